// File: rtl/bus_arb_pkg.sv
// Shared constants and helpers for the bus host arbiter.
//   MaxHosts  : upper bound on the number of hosts one arbiter may serve
//   idx_width : width of an index into n entries, never less than one bit
package bus_arb_pkg;

   localparam int MaxHosts = 8;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of host indices for accepted-but-unanswered transactions.
// The head is the registered oldest entry (no fall-through). A push while full
// or a pop while empty is ignored.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   push_i        : enqueue push_data_i
//   push_data_i   : entry to enqueue
//   pop_i         : dequeue the head
//   head_o        : oldest entry (undefined while empty)
//   full_o        : occupancy equals Depth
//   empty_o       : occupancy is zero
//   count_o       : current occupancy
module arb_id_fifo
   import bus_arb_pkg::*;
#(
   parameter  int Width = 1,
   parameter  int Depth = 2,
   localparam int CntW  = $clog2(Depth + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [Width-1:0] push_data_i,
   input  logic             pop_i,
   output logic [Width-1:0] head_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CntW-1:0]  count_o
);

   localparam int PtrW = idx_width(Depth);
   localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
   localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [Width-1:0] mem_d [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             do_push, do_pop;

   // Pointers wrap modulo Depth, which need not be a power of two.
   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == LastPtr) ? '0 : p + PtrW'(1);
   endfunction

   assign full_o  = (count_q == DepthCnt);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data_i;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; only entries between the pointers are ever read.
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/bus_host_arbiter.sv
// Round-robin arbiter sharing one pipelined req/gnt/rvalid device port among
// several hosts. The issuing host of every accepted transaction is queued so
// in-order responses are routed back to the right host.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   host_req_i/gnt_o      : per-host request / same-cycle grant
//   host_addr/we/be/wdata : packed per-host command fields
//   host_rvalid_o/err_o   : per-host response strobe and error
//   host_rdata_o          : response data, broadcast to every host
//   device_*              : single shared device port
//   outstanding_o         : transactions accepted but not yet answered
//   unexpected_rsp_o      : sticky, a response arrived with nothing outstanding
module bus_host_arbiter
   import bus_arb_pkg::*;
#(
   parameter  int NrHosts        = 2,
   parameter  int DataWidth      = 32,
   parameter  int AddressWidth   = 32,
   parameter  int MaxOutstanding = 2,
   localparam int CntW           = $clog2(MaxOutstanding + 1)
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [NrHosts-1:0]              host_req_i,
   output logic [NrHosts-1:0]              host_gnt_o,
   input  logic [NrHosts*AddressWidth-1:0] host_addr_i,
   input  logic [NrHosts-1:0]              host_we_i,
   input  logic [NrHosts*4-1:0]            host_be_i,
   input  logic [NrHosts*DataWidth-1:0]    host_wdata_i,
   output logic [NrHosts-1:0]              host_rvalid_o,
   output logic [DataWidth-1:0]            host_rdata_o,
   output logic [NrHosts-1:0]              host_err_o,
   output logic                            device_req_o,
   input  logic                            device_gnt_i,
   output logic [AddressWidth-1:0]         device_addr_o,
   output logic                            device_we_o,
   output logic [3:0]                      device_be_o,
   output logic [DataWidth-1:0]            device_wdata_o,
   input  logic                            device_rvalid_i,
   input  logic [DataWidth-1:0]            device_rdata_i,
   input  logic                            device_err_i,
   output logic [CntW-1:0]                 outstanding_o,
   output logic                            unexpected_rsp_o
);

   localparam int IdxW  = idx_width(NrHosts);
   localparam int CandW = IdxW + 1;
   localparam logic [CandW-1:0] NrHostsC = CandW'(NrHosts);
   localparam logic [IdxW-1:0]  LastHost = IdxW'(NrHosts - 1);

   logic [IdxW-1:0]         rr_ptr_q, rr_ptr_d;
   logic                    unexpected_q, unexpected_d;
   logic [IdxW-1:0]         winner;
   logic [CandW-1:0]        cand;
   logic                    found;
   logic                    accept, rsp_ok;
   logic                    fifo_full, fifo_empty;
   logic [IdxW-1:0]         rsp_host;

   logic [AddressWidth-1:0] addr_arr  [NrHosts];
   logic [3:0]              be_arr    [NrHosts];
   logic [DataWidth-1:0]    wdata_arr [NrHosts];

   for (genvar g = 0; g < NrHosts; g++) begin : g_unpack
      assign addr_arr[g]  = host_addr_i[g*AddressWidth +: AddressWidth];
      assign be_arr[g]    = host_be_i[g*4 +: 4];
      assign wdata_arr[g] = host_wdata_i[g*DataWidth +: DataWidth];
   end

   // First requester at or after rr_ptr, searching cyclically. With no
   // requester the winner stays 0 so the command muxes follow host 0.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      cand   = '0;
      for (int i = 0; i < NrHosts; i++) begin
         cand = {1'b0, rr_ptr_q} + CandW'(i);
         if (cand >= NrHostsC) begin
            cand = cand - NrHostsC;
         end
         if (!found && host_req_i[cand[IdxW-1:0]]) begin
            found  = 1'b1;
            winner = cand[IdxW-1:0];
         end
      end
   end

   // Full blocks requests even when a pop lands in the same cycle, so there is
   // no combinational path from device_rvalid_i to device_req_o.
   assign device_req_o   = ~rst_i & (|host_req_i) & ~fifo_full;
   assign accept         = device_req_o & device_gnt_i;

   assign device_addr_o  = addr_arr[winner];
   assign device_we_o    = host_we_i[winner];
   assign device_be_o    = be_arr[winner];
   assign device_wdata_o = wdata_arr[winner];

   assign rsp_ok         = ~rst_i & device_rvalid_i & ~fifo_empty;
   assign host_rdata_o   = device_rdata_i;

   always_comb begin
      host_gnt_o    = '0;
      host_rvalid_o = '0;
      host_err_o    = '0;
      for (int i = 0; i < NrHosts; i++) begin
         if (accept && (winner == IdxW'(i))) begin
            host_gnt_o[i] = 1'b1;
         end
         if (rsp_ok && (rsp_host == IdxW'(i))) begin
            host_rvalid_o[i] = 1'b1;
            host_err_o[i]    = device_err_i;
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (accept) begin
         rr_ptr_d = (winner == LastHost) ? '0 : winner + IdxW'(1);
      end
      unexpected_d = unexpected_q | (device_rvalid_i & fifo_empty);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr_q     <= '0;
         unexpected_q <= 1'b0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         unexpected_q <= unexpected_d;
      end
   end

   assign unexpected_rsp_o = unexpected_q;

   arb_id_fifo #(
      .Width (IdxW),
      .Depth (MaxOutstanding)
   ) u_id_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (accept),
      .push_data_i (winner),
      .pop_i       (device_rvalid_i),
      .head_o      (rsp_host),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .count_o     (outstanding_o)
   );

endmodule

// File: tb/tb_bus_host_arbiter.sv
module tb_bus_host_arbiter;

   localparam int N  = 2;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int MO = 2;
   localparam int CW = $clog2(MO + 1);
   localparam int CMDW = AW + 1 + 4 + DW;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic [N-1:0]      host_req_i;
   logic [N-1:0]      host_gnt_o;
   logic [N*AW-1:0]   host_addr_i;
   logic [N-1:0]      host_we_i;
   logic [N*4-1:0]    host_be_i;
   logic [N*DW-1:0]   host_wdata_i;
   logic [N-1:0]      host_rvalid_o;
   logic [DW-1:0]     host_rdata_o;
   logic [N-1:0]      host_err_o;
   logic              device_req_o;
   logic              device_gnt_i;
   logic [AW-1:0]     device_addr_o;
   logic              device_we_o;
   logic [3:0]        device_be_o;
   logic [DW-1:0]     device_wdata_o;
   logic              device_rvalid_i;
   logic [DW-1:0]     device_rdata_i;
   logic              device_err_i;
   logic [CW-1:0]     outstanding_o;
   logic              unexpected_rsp_o;

   always #5 clk_i = ~clk_i;

   bus_host_arbiter #(
      .NrHosts        (N),
      .DataWidth      (DW),
      .AddressWidth   (AW),
      .MaxOutstanding (MO)
   ) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .host_req_i       (host_req_i),
      .host_gnt_o       (host_gnt_o),
      .host_addr_i      (host_addr_i),
      .host_we_i        (host_we_i),
      .host_be_i        (host_be_i),
      .host_wdata_i     (host_wdata_i),
      .host_rvalid_o    (host_rvalid_o),
      .host_rdata_o     (host_rdata_o),
      .host_err_o       (host_err_o),
      .device_req_o     (device_req_o),
      .device_gnt_i     (device_gnt_i),
      .device_addr_o    (device_addr_o),
      .device_we_o      (device_we_o),
      .device_be_o      (device_be_o),
      .device_wdata_o   (device_wdata_o),
      .device_rvalid_i  (device_rvalid_i),
      .device_rdata_i   (device_rdata_i),
      .device_err_i     (device_err_i),
      .outstanding_o    (outstanding_o),
      .unexpected_rsp_o (unexpected_rsp_o)
   );

   typedef struct {
      int          host;
      logic [31:0] rdata;
      logic        err;
   } txn_t;

   // Reference model: outstanding transactions as seen by the device, the
   // expected-response scoreboard, and the round-robin pointer as a plain int.
   txn_t dev_q[$];
   txn_t exp_q[$];
   int   rr;
   bit   unexp_m;

   // Decisions of the cycle currently on the pins, retired at the next edge.
   bit   c_rst = 1'b1;
   bit   c_acc, c_pop, c_unexp;
   int   c_win;

   // Expectations for the cycle currently on the pins.
   bit              e_req, e_pop, e_unexp;
   logic [N-1:0]    e_gnt;
   int              e_out;
   logic [CMDW-1:0] e_cmd;

   logic [AW-1:0] t_addr  [N];
   logic          t_we    [N];
   logic [3:0]    t_be    [N];
   logic [DW-1:0] t_wdata [N];

   bit chk_en = 1'b0;
   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // One clock of stimulus. rmode: 0 = device silent, 1 = respond to the
   // oldest outstanding transaction if any, 2 = assert rvalid regardless.
   task automatic step(input bit rst, input logic [N-1:0] req, input bit gnt, input int rmode);
      txn_t t;
      bit   any;
      int   occ;
      int   h;
      @(posedge clk_i);
      #1;
      if (c_rst) begin
         dev_q.delete();
         exp_q.delete();
         rr      = 0;
         unexp_m = 1'b0;
      end else begin
         if (c_unexp) unexp_m = 1'b1;
         if (c_pop) t = dev_q.pop_front();
         if (c_acc) begin
            t.host  = c_win;
            t.rdata = $urandom;
            t.err   = ($urandom_range(0, 3) == 0);
            dev_q.push_back(t);
            exp_q.push_back(t);
            rr = (c_win + 1) % N;
         end
      end

      rst_i        = rst;
      host_req_i   = req;
      device_gnt_i = gnt;
      for (int i = 0; i < N; i++) begin
         t_addr[i]  = $urandom;
         t_we[i]    = $urandom_range(0, 1);
         t_be[i]    = 4'($urandom);
         t_wdata[i] = $urandom;
         host_addr_i[i*AW +: AW]  = t_addr[i];
         host_we_i[i]             = t_we[i];
         host_be_i[i*4 +: 4]      = t_be[i];
         host_wdata_i[i*DW +: DW] = t_wdata[i];
      end

      occ = dev_q.size();
      device_rvalid_i = ((rmode == 1) && (occ > 0)) || (rmode == 2);
      if (device_rvalid_i && occ > 0) begin
         device_rdata_i = dev_q[0].rdata;
         device_err_i   = dev_q[0].err;
      end else begin
         device_rdata_i = $urandom;
         device_err_i   = $urandom_range(0, 1);
      end

      any   = 1'b0;
      c_win = 0;
      for (int k = 0; k < N; k++) begin
         h = (rr + k) % N;
         if (!any && req[h]) begin
            any   = 1'b1;
            c_win = h;
         end
      end
      e_req   = !rst && any && (occ < MO);
      c_acc   = e_req && gnt;
      e_gnt   = '0;
      if (c_acc) e_gnt[c_win] = 1'b1;
      c_pop   = !rst && device_rvalid_i && (occ > 0);
      c_unexp = !rst && device_rvalid_i && (occ == 0);
      c_rst   = rst;
      e_pop   = c_pop;
      e_out   = occ;
      e_unexp = unexp_m;
      e_cmd   = {t_addr[c_win], t_we[c_win], t_be[c_win], t_wdata[c_win]};
   endtask

   task automatic drain();
      for (int i = 0; i < 4 * MO + 4; i++) begin
         step(1'b0, '0, 1'b0, 1);
      end
   endtask

   // Monitor: per-cycle control checks plus scoreboard pop whenever the DUT
   // presents a response.
   initial begin
      txn_t         mt;
      logic [N-1:0] onehot;
      forever begin
         @(negedge clk_i);
         if (chk_en) begin
            chk("device_req", 128'(device_req_o), 128'(e_req));
            chk("host_gnt", 128'(host_gnt_o), 128'(e_gnt));
            chk("outstanding", 128'(outstanding_o), 128'(e_out));
            chk("unexpected_rsp", 128'(unexpected_rsp_o), 128'(e_unexp));
            chk("rvalid_present", 128'(|host_rvalid_o), 128'(e_pop));
            if (e_req) begin
               chk("device_cmd",
                   128'({device_addr_o, device_we_o, device_be_o, device_wdata_o}),
                   128'(e_cmd));
            end
            if (host_rvalid_o != '0) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL rsp_scoreboard at %0t: got rvalid %b expected no response", $time, host_rvalid_o);
               end else begin
                  mt = exp_q.pop_front();
                  onehot = '0;
                  onehot[mt.host] = 1'b1;
                  chk("rsp_rvalid", 128'(host_rvalid_o), 128'(onehot));
                  chk("rsp_err", 128'(host_err_o), 128'(mt.err ? onehot : '0));
                  chk("rsp_rdata", 128'(host_rdata_o), 128'(mt.rdata));
               end
            end else begin
               chk("host_err_idle", 128'(host_err_o), 128'(0));
               if (e_pop && exp_q.size() > 0) mt = exp_q.pop_front();
            end
         end
      end
   end

   initial begin
      rst_i           = 1'b1;
      host_req_i      = '0;
      host_addr_i     = '0;
      host_we_i       = '0;
      host_be_i       = '0;
      host_wdata_i    = '0;
      device_gnt_i    = 1'b0;
      device_rvalid_i = 1'b0;
      device_rdata_i  = '0;
      device_err_i    = 1'b0;
      repeat (2) @(posedge clk_i);

      step(1'b1, '0, 1'b0, 0);
      chk_en = 1'b1;
      // reset forces grants and responses low even with traffic present
      step(1'b1, 2'b11, 1'b1, 2);

      // single host: grant, response next cycle
      step(1'b0, 2'b01, 1'b1, 0);
      step(1'b0, 2'b00, 1'b0, 1);
      step(1'b0, 2'b00, 1'b0, 0);

      // contention with immediate responses: grants alternate
      repeat (8) step(1'b0, 2'b11, 1'b1, 1);
      drain();

      // full stall, then responses release the next grants
      repeat (6) step(1'b0, 2'b11, 1'b1, 0);
      repeat (4) step(1'b0, 2'b11, 1'b1, 1);
      drain();

      // host 1 alone, many responses so the error path toward host 1 is hit
      repeat (12) step(1'b0, 2'b10, 1'b1, 1);
      drain();

      // unexpected response is dropped and sticky until reset
      step(1'b0, '0, 1'b0, 2);
      repeat (3) step(1'b0, '0, 1'b0, 0);
      step(1'b1, '0, 1'b0, 0);
      step(1'b0, '0, 1'b0, 0);

      // reset mid-flight: outstanding IDs discarded, rr_ptr back to host 0
      step(1'b0, 2'b11, 1'b1, 0);
      step(1'b0, 2'b11, 1'b1, 0);
      step(1'b1, 2'b11, 1'b1, 0);
      step(1'b0, '0, 1'b0, 2);
      step(1'b0, 2'b11, 1'b1, 0);
      step(1'b0, 2'b11, 1'b1, 1);
      drain();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 299) == 0),
              N'($urandom),
              ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 99) == 0) ? 2 : (($urandom_range(0, 9) < 6) ? 1 : 0));
      end
      drain();
      step(1'b0, '0, 1'b0, 0);
      @(negedge clk_i);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/bus_host_arbiter.md
Name: bus_host_arbiter

Overview:
- Round-robin arbiter that lets several bus hosts share one device port, e.g. the Ibex instruction and data ports on a single-port RAM, or extra hosts ahead of the system bus.
- Accepts pipelined req/gnt/rvalid transactions.
- Tracks the issuing host of every outstanding request in an in-order ID FIFO, so each response goes back to the host that issued it.
- Sits between the hosts and the bus or device.

Parameters:
- NrHosts, 2, number of requesting hosts (2..8).
- DataWidth, 32, data width.
- AddressWidth, 32, address width.
- MaxOutstanding, 2, depth of the ID FIFO, i.e. maximum accepted-but-unanswered transactions (1..8).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- host_req_i  in  NrHosts  per-host request.
- host_gnt_o  out  NrHosts  per-host grant.
- host_addr_i  in  NrHosts*AddressWidth  packed per-host address.
- host_we_i  in  NrHosts  write enable.
- host_be_i  in  NrHosts*4  byte enables.
- host_wdata_i  in  NrHosts*DataWidth  write data.
- host_rvalid_o  out  NrHosts  per-host response valid.
- host_rdata_o  out  DataWidth  response data, broadcast to all hosts.
- host_err_o  out  NrHosts  per-host response error.
- device_req_o  out  1  request to the device.
- device_gnt_i  in  1  device grant.
- device_addr_o  out  AddressWidth  address.
- device_we_o  out  1  write enable.
- device_be_o  out  4  byte enables.
- device_wdata_o  out  DataWidth  write data.
- device_rvalid_i  in  1  response valid.
- device_rdata_i  in  DataWidth  response data.
- device_err_i  in  1  response error.
- outstanding_o  out  $clog2(MaxOutstanding+1)  current ID FIFO occupancy.
- unexpected_rsp_o  out  1  sticky flag: response received with no transaction outstanding.

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is synchronous and active-high (rst_i).
  - While rst_i is high, all combinational outputs are forced to 0: device_req_o, host_gnt_o, host_rvalid_o, host_err_o.
  - On reset, rr_ptr=0, the ID FIFO is empty (outstanding_o=0) and unexpected_rsp_o=0.
- Arbitration (combinational):
  - The winner is the first requesting host at or after rr_ptr, searching cyclically.
  - device_req_o = |host_req_i & ~fifo_full.
  - device_addr/we/be/wdata are muxed from the winner.
  - When device_req_o=0 these outputs are don't-care; drive them from host 0.
  - host_gnt_o[winner] = device_req_o & device_gnt_i. All other grants are 0.
  - Zero-cycle grant latency: a request and its grant can occur in the same cycle.
- Accept:
  - On device_req_o & device_gnt_i: push the winner index into the ID FIFO and set rr_ptr <= (winner+1) mod NrHosts.
  - rr_ptr is unchanged in all other cycles.
  - A host holding its request is served again only after every other requester has had one grant. This gives fairness with a bound of NrHosts-1 grants of wait.
- Response:
  - The device returns responses in order, one per accepted transaction, at least one cycle after the grant.
  - On device_rvalid_i with the FIFO non-empty: pop the head h; host_rvalid_o[h]=1 and host_err_o[h]=device_err_i, in the same cycle as device_rvalid_i. All other hosts see 0.
  - host_rdata_o = device_rdata_i, unregistered.
- Full:
  - When occupancy == MaxOutstanding, device_req_o=0, even if a pop happens in the same cycle.
  - This deliberately avoids an rvalid-to-req combinational path.
  - Requesting hosts simply see no grant and must hold their request.
- Simultaneous push and pop (not full): occupancy is unchanged and FIFO order is preserved.
- Unexpected response:
  - device_rvalid_i with the FIFO empty is dropped: no host_rvalid_o.
  - unexpected_rsp_o is set and stays set until reset.
- Reset mid-operation: outstanding IDs are discarded. Any later device_rvalid_i for those transactions counts as unexpected.
- Widths: host index width is IdxW = max(1, $clog2(NrHosts)). FIFO pointers wrap modulo MaxOutstanding.

Decomposition:
- Package bus_arb_pkg holds:
  - MaxHosts=8.
  - The function idx_width(n) returning max(1, $clog2(n)).
  - The typedef arb_rsp_t {logic err; logic [DataWidth-1:0] rdata} is not required; keep the package to constants and functions only.
- Sub-module arb_id_fifo (parameters Width, Depth):
  - Synchronous active-high reset.
  - push/pop/full/empty/count/head ports.
  - No fall-through; pop on empty is ignored.
- The top level contains the round-robin pick, muxes and response routing.

Test Plan:
- Single host: NrHosts=2, host 0 requests addr 0x0100_0080, device_gnt_i=1, rvalid one cycle later with rdata=0xDEADBEEF → host_gnt_o=2'b01 in cycle 0; host_rvalid_o=2'b01 in cycle 1; host_rdata_o=0xDEADBEEF; outstanding_o goes 1 then 0.
- Contention: both hosts request continuously, gnt=1 → grants alternate 01,10,01,10 starting with host 0 after reset; rvalids are routed in the same order.
- Full stall: MaxOutstanding=2, device withholds rvalid for 4 cycles → exactly 2 grants, device_req_o=0 while outstanding_o=2. The first rvalid pops without a same-cycle grant; the next grant comes in the following cycle.
- Error routing: host 1 read, device_err_i=1 on its response → host_err_o=2'b10 and host_rvalid_o=2'b10.
- Unexpected response: rvalid with outstanding_o=0 → no host_rvalid_o; unexpected_rsp_o=1 and held until rst_i pulse.
- Reset mid-flight: two grants outstanding, then rst_i for 1 cycle → outstanding_o=0 and rr_ptr=0 (next contention grant goes to host 0). A following rvalid sets unexpected_rsp_o.
